// File: rtl/phy_symbols_pkg.sv
// Line symbols and state encoding for the serial PHY.
// Used by both the transmit and receive sides.
package phy_symbols_pkg;

  localparam logic [7:0] COM_SYM_DEF  = 8'hBC;
  localparam logic [7:0] IDLE_SYM_DEF = 8'h7C;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } tx_state_e;

endpackage

// File: rtl/piso_shift8.sv
// 8-bit parallel-in serial-out register.
// The MSB is presented straight from the flop.
module piso_shift8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] din,
  output logic       dout
);

  logic [7:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= 8'h00;
    end else if (load) begin
      sr <= din;
    end else begin
      sr <= {sr[6:0], 1'b0};
    end
  end

  assign dout = sr[7];

endmodule

// File: rtl/par2serial_tx.sv
// Byte-to-bit serializer with COM sync train.
// Sends SYNC_SYMBOLS commas, then data or IDLE.
module par2serial_tx
  import phy_symbols_pkg::*;
#(
  parameter logic [7:0] COM_SYM      = COM_SYM_DEF,
  parameter logic [7:0] IDLE_SYM     = IDLE_SYM_DEF,
  parameter int         SYNC_SYMBOLS = 4
) (
  input  logic       clk32f,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       valid,
  output logic       out,
  output logic       ready,
  output logic       active
);

  localparam logic [7:0] LAST_COM = 8'(SYNC_SYMBOLS - 1);

  tx_state_e  state;
  tx_state_e  nxt_state;
  logic [2:0] bit_cnt;
  logic [2:0] nxt_bit;
  logic [7:0] com_cnt;
  logic       load;
  logic [7:0] sym;

  always_comb begin
    load      = (bit_cnt == 3'd7);
    nxt_bit   = bit_cnt + 3'd1;
    nxt_state = state;
    sym       = COM_SYM;
    if (state == ACTIVE) begin
      sym = valid ? in : IDLE_SYM;
    end else if (load && com_cnt == LAST_COM) begin
      nxt_state = ACTIVE;
    end
  end

  always_ff @(posedge clk32f) begin
    if (reset) begin
      bit_cnt <= 3'd7;
      state   <= SYNC;
      com_cnt <= 8'd0;
      active  <= 1'b0;
      ready   <= 1'b0;
    end else begin
      bit_cnt <= nxt_bit;
      state   <= nxt_state;
      if (load && state == SYNC) begin
        com_cnt <= com_cnt + 8'd1;
      end
      active <= (nxt_state == ACTIVE);
      ready  <= (nxt_state == ACTIVE) &&
                (nxt_bit == 3'd7);
    end
  end

  piso_shift8 u_piso (
    .clk   (clk32f),
    .reset (reset),
    .load  (load),
    .din   (sym),
    .dout  (out)
  );

endmodule

// File: tb/tb_par2serial_tx.sv
// Scoreboard bench for par2serial_tx.
// Second instance covers a one-symbol sync train.
module tb_par2serial_tx;

  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;

  logic       clk32f = 1'b0;
  logic       reset;
  logic [7:0] in_d;
  logic       valid;
  logic       out, ready, active;
  logic       out1, ready1, active1;

  logic q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk32f = ~clk32f;

  par2serial_tx #(.SYNC_SYMBOLS(4)) u_dut (
    .clk32f (clk32f),
    .reset  (reset),
    .in     (in_d),
    .valid  (valid),
    .out    (out),
    .ready  (ready),
    .active (active)
  );

  par2serial_tx #(.SYNC_SYMBOLS(1)) u_one (
    .clk32f (clk32f),
    .reset  (reset),
    .in     (in_d),
    .valid  (valid),
    .out    (out1),
    .ready  (ready1),
    .active (active1)
  );

  task automatic check(input string tag,
                       input logic got,
                       input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk32f);
    #1;
  endtask

  task automatic push_sym(input logic [7:0] s);
    for (int i = 7; i >= 0; i--) q.push_back(s[i]);
  endtask

  task automatic check_out(input string tag);
    logic e;
    if (q.size() == 0) begin
      check({tag, "_q_empty"}, 1'b1, 1'b0);
    end else begin
      e = q.pop_front();
      check(tag, out, e);
    end
  endtask

  task automatic check_reset_state();
    check("rst_out", out, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_active", active, 1'b0);
    check("rst_out1", out1, 1'b0);
    check("rst_ready1", ready1, 1'b0);
    check("rst_active1", active1, 1'b0);
  endtask

  // Called with reset just released; covers the full sync train.
  task automatic sync_check();
    logic [7:0] com_v;
    com_v = COM;
    for (int i = 0; i < 4; i++) push_sym(COM);
    for (int i = 0; i < 32; i++) begin
      tick();
      check_out("sync_out");
      check("sync_ready", ready, i == 31);
      check("sync_active", active, i >= 24);
      check("one_active", active1, 1'b1);
      check("one_ready", ready1, (i % 8) == 7);
      if (i < 8) check("one_out", out1, com_v[7 - i]);
    end
  endtask

  // Entered with ready high; in changes to junk mid-frame.
  task automatic frame(input logic [7:0] d,
                       input logic       v,
                       input logic [7:0] junk);
    in_d  = d;
    valid = v;
    push_sym(v ? d : IDLE);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_out("data_out");
      check("data_ready", ready, k == 7);
      check("data_active", active, 1'b1);
      if (k == 0) begin
        in_d  = junk;
        valid = 1'b1;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    in_d  = 8'hFF;
    valid = 1'b1;
    tick();
    tick();
    check_reset_state();
    reset = 1'b0;
    sync_check();

    frame(8'hA5, 1'b1, 8'(($urandom)));
    frame(8'h33, 1'b0, 8'(($urandom)));
    frame(8'h01, 1'b1, 8'(($urandom)));
    frame(8'h80, 1'b1, 8'(($urandom)));
    frame(8'hFF, 1'b1, 8'(($urandom)));
    frame(8'h00, 1'b1, 8'h5A);
    frame(8'hC3, 1'b1, 8'(($urandom)));
    frame(COM,   1'b1, 8'(($urandom)));
    frame(IDLE,  1'b1, 8'(($urandom)));

    in_d  = 8'hA5;
    valid = 1'b1;
    push_sym(8'hA5);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_out("pre_rst_out");
    end
    reset = 1'b1;
    tick();
    check_reset_state();
    q.delete();
    reset = 1'b0;
    in_d  = 8'hFF;
    sync_check();
    frame(8'h96, 1'b1, 8'(($urandom)));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
